input_debounce_sync: RTL and testbench
======================================

Name: input_debounce_sync

Overview:
Conditions one asynchronous, possibly bouncing input (pad, switch, external strobe) before it drives downstream positive-edge flip-flops.
- A SYNC_STAGES-deep flip-flop synchronizer feeds a debounce counter/FSM.
- Outputs are a clean registered level plus one-cycle rise/fall pulses.
- Sits directly upstream of the design's DFF-based control logic, so no asynchronous or glitchy edge reaches a D pin.

Parameters:
SYNC_STAGES, 2, synchronizer flop count; legal range 2..4
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before Q changes; legal range 1..2**CNT_W
CNT_W, 8, debounce counter width
RESET_VAL, 1'b0, reset value of sync chain and Q

Ports:
CLK  input  1  sole clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
D  input  1  raw asynchronous input
EN  input  1  debounce enable; 0 freezes counter and Q
Q  output  1  debounced, synchronized level
RISE  output  1  one-cycle pulse when Q goes 0->1
FALL  output  1  one-cycle pulse when Q goes 1->0
BUSY  output  1  1 while synchronized input differs from Q

Behaviour:
Reset:
- RST=1 asynchronously sets sync chain and Q to RESET_VAL.
- Clears counter, RISE, FALL.
- BUSY=0 during reset.
- Deassertion takes effect at the first CLK edge after RST falls. The integrator guarantees synchronous deassertion of RST.

Synchronizer:
- Stage 1 samples D each edge; stage i samples stage i-1.
- Last stage is "s". No enable and no logic between stages.

Debounce FSM:
- Two states, STABLE and PENDING. State is encoded as (s != Q); no extra state flop.
- At each edge with EN=1:
  - s == Q: cnt <= 0; stay STABLE.
  - s != Q and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1 (PENDING).
  - s != Q and cnt == DEBOUNCE_CYCLES-1: Q <= s, cnt <= 0, pulse RISE (if s=1) or FALL (if s=0) for exactly that cycle.
- At each edge with EN=0: cnt, Q hold; RISE/FALL <= 0. Sync chain keeps running.
- EN is sampled at the same edge as the commit condition. If EN=0 on the would-be commit edge, there is no commit; commit occurs on the first later edge with EN=1 and s != Q.

Latency:
- D changes and is held stable. Edge 1 is the first edge that samples the new value.
- Q, RISE/FALL update after edge SYNC_STAGES + DEBOUNCE_CYCLES (default: edge 18).

Glitch rejection:
- Any return of s to Q before commit clears cnt. The event is dropped: no pulse, Q unchanged.

Output timing:
- BUSY = (s != Q), combinational from flops.
- RISE and FALL are registered and mutually exclusive. Never both 1 in one cycle.

Counter rules:
- cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- DEBOUNCE_CYCLES=1 commits on the first edge seeing s != Q.

Reset mid-PENDING: all state lost; Q returns to RESET_VAL with no pulse.

Decomposition:
- No typedefs needed.
- Shared package holds the default constants SYNC_STAGES_DEF=2 and DEBOUNCE_CYCLES_DEF=16, plus a function computing the minimum CNT_W for a given DEBOUNCE_CYCLES.
- One natural sub-module: sync_chain (parameterized SYNC_STAGES, async active-high reset to RESET_VAL), reusable for other asynchronous inputs.
- Debounce counter/FSM stays in the top module.

Test Plan:
1. RST=1 with D=1, no clock -> Q=0, RISE=FALL=0, BUSY=0 immediately. Release RST, hold D=1 -> BUSY=1 after edge 2; RISE=1 and Q=1 after edge 18; RISE=0 after edge 19.
2. Q=1, D pulses low for 10 cycles (< 16 post-sync) -> no FALL, Q stays 1, BUSY returns to 0. Then D low for 20 cycles -> FALL exactly once, 18 edges after the first sampled low.
3. Bounce: D toggles every 3 cycles for 60 cycles, then settles to 1 -> no pulses during bouncing; a single RISE 18 edges after final settle.
4. EN=0 from edge 10 to edge 30 while D=1 is pending -> cnt frozen, Q=0 throughout; after EN=1 at edge 30, commit occurs 8 edges later (cnt resumes from 8).
5. RST pulse asserted mid-PENDING (cnt=12) -> Q, cnt clear asynchronously, no pulse. After release with D still 1, full 18-edge latency restarts.
6. DEBOUNCE_CYCLES=1, SYNC_STAGES=3 -> D 0->1 gives RISE after edge 4; one-cycle D glitch still propagates (documented minimum filtering).

Source files
------------

// File: rtl/input_debounce_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_sync_pkg
// Brief    : Shared defaults and sizing helper for the input debounce slice.
// Revision : 1.0
// ============================================================================
package input_debounce_sync_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Counter only ever holds 0..cycles-1, so one bit fewer than a full count.
    function automatic int min_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debounce_sync_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : Plain N-flop synchronizer with async active-high reset.
// Revision : 1.0
// ============================================================================
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_s
);

    logic [SYNC_STAGES-1:0] r_chain;

    // No logic between stages: each flop only sees the previous flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_s = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/input_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_sync
// Brief    : Synchronizes and debounces one async input; level + edge pulses.
// Revision : 1.0
// ============================================================================
module input_debounce_sync
    import input_debounce_sync_pkg::*;
#(
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int   CNT_W           = 8,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    input  logic EN,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    localparam logic             c_ST_STABLE  = 1'b0;
    localparam logic             c_ST_PENDING = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_s;
    logic             w_state;
    logic             r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             w_q_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .i_d (D),
        .o_s (w_s)
    );

    // The state is implied by the mismatch between synchronized input and Q.
    assign w_state = (w_s != r_q) ? c_ST_PENDING : c_ST_STABLE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q    <= RESET_VAL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_cnt  <= w_cnt_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    always_comb begin
        w_q_nxt    = r_q;
        w_cnt_nxt  = r_cnt;
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        if (EN) begin
            if (w_state == c_ST_STABLE) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == c_CNT_LAST) begin
                w_q_nxt    = w_s;
                w_cnt_nxt  = '0;
                w_rise_nxt = w_s;
                w_fall_nxt = ~w_s;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    assign Q    = r_q;
    assign RISE = r_rise;
    assign FALL = r_fall;
    assign BUSY = (w_state == c_ST_PENDING);

endmodule
`default_nettype wire

// File: tb/tb_input_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debounce_sync
// Brief    : Bench for input_debounce_sync (default and minimum-filter builds).
// Revision : 1.0
// ============================================================================
module tb_input_debounce_sync;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic D   = 1'b0;
    logic EN  = 1'b1;
    logic q0, r0, f0, b0;
    logic q1, r1, f1, b1;

    int checks = 0;
    int errors = 0;
    int rise_n = 0;
    int fall_n = 0;

    always #5 CLK = ~CLK;

    input_debounce_sync dut (
        .CLK (CLK), .RST (RST), .D (D), .EN (EN),
        .Q (q0), .RISE (r0), .FALL (f0), .BUSY (b0)
    );

    input_debounce_sync #(
        .SYNC_STAGES (3), .DEBOUNCE_CYCLES (1), .CNT_W (8), .RESET_VAL (1'b0)
    ) dut6 (
        .CLK (CLK), .RST (RST), .D (D), .EN (EN),
        .Q (q1), .RISE (r1), .FALL (f1), .BUSY (b1)
    );

    // Reference: s is D as sampled SS edges ago; Q flips after DC consecutive
    // enabled edges on which s differed from Q.
    int ss[2] = '{2, 3};
    int dc[2] = '{16, 1};
    bit hq[$];
    int run[2];
    bit mq[2];
    bit mr[2];
    bit mf[2];

    function automatic bit s_of(input int i);
        return (hq.size() >= ss[i]) ? hq[hq.size() - ss[i]] : 1'b0;
    endfunction

    always @(posedge CLK or posedge RST) begin
        bit sp;
        if (RST) begin
            hq.delete();
            for (int i = 0; i < 2; i++) begin
                run[i] = 0; mq[i] = 0; mr[i] = 0; mf[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                sp = s_of(i);
                mr[i] = 0;
                mf[i] = 0;
                if (EN) begin
                    if (sp != mq[i]) begin
                        run[i]++;
                        if (run[i] == dc[i]) begin
                            mq[i]  = sp;
                            run[i] = 0;
                            mr[i]  = sp;
                            mf[i]  = !sp;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
            end
            hq.push_back(D);
            if (hq.size() > 8) void'(hq.pop_front());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            chk("dut q/rise/fall/busy", {q0, r0, f0, b0},
                {mq[0], mr[0], mf[0], s_of(0) != mq[0]});
            chk("dut6 q/rise/fall/busy", {q1, r1, f1, b1},
                {mq[1], mr[1], mf[1], s_of(1) != mq[1]});
            chk("rise/fall exclusive", {r0 & f0, r1 & f1}, 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        rise_n += int'(r0);
        fall_n += int'(f0);
    endtask

    task automatic hold(input logic v, input int n);
        D = v;
        repeat (n) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe;
        int re;
        int v;
        int len;

        // Reset with D high, before any clock edge.
        D = 1'b1;
        #3;
        chk("reset q/rise/fall/busy", {q0, r0, f0, b0}, 0);
        chk("reset dut6 q/busy", {q1, b1}, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e == 1)  chk("busy after edge1", b0, 0);
            if (e == 2)  chk("busy after edge2", b0, 1);
            if (e == 4)  chk("dut6 rise,q edge4", {r1, q1}, 2'b11);
            if (e == 5)  chk("dut6 rise edge5", r1, 0);
            if (e == 17) chk("rise,q edge17", {r0, q0}, 2'b00);
            if (e == 18) chk("rise,q edge18", {r0, q0}, 2'b11);
            if (e == 19) chk("rise,q edge19", {r0, q0}, 2'b01);
        end
        hold(1'b1, 5);

        // Short low pulse filtered, long low commits.
        fall_n = 0;
        hold(1'b0, 10);
        hold(1'b1, 30);
        chk("short low no fall", fall_n, 0);
        chk("short low q held", q0, 1);
        D = 1'b0;
        fe = 0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (f0 && fe == 0) fe = e;
        end
        chk("fall edge", fe, 18);
        chk("fall count", fall_n, 1);

        // Bounce, then settle high.
        rise_n = 0;
        for (int k = 0; k < 20; k++) hold((k % 2 == 0) ? 1'b1 : 1'b0, 3);
        chk("bounce no rise", rise_n, 0);
        D = 1'b1;
        re = 0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (r0 && re == 0) re = e;
        end
        chk("settle rise edge", re, 18);
        chk("settle rise count", rise_n, 1);

        // Enable frozen mid-pending.
        hold(1'b0, 30);
        D = 1'b1;
        re = 0;
        for (int e = 1; e <= 45; e++) begin
            tick();
            if (e == 10) EN = 1'b0;
            if (e == 30) begin
                chk("q frozen at edge30", q0, 0);
                EN = 1'b1;
            end
            if (r0 && re == 0) re = e;
        end
        chk("en resume rise edge", re, 38);

        // Async reset mid-pending.
        hold(1'b0, 30);
        D = 1'b1;
        repeat (14) tick();
        chk("pending busy", b0, 1);
        rise_n = 0;
        RST = 1'b1;
        #1;
        chk("async reset q/rise/busy", {q0, r0, b0}, 0);
        chk("async reset dut6 q", q1, 0);
        repeat (3) tick();
        RST = 1'b0;
        re = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (r0 && re == 0) re = e;
        end
        chk("post-reset rise edge", re, 18);
        chk("post-reset rise count", rise_n, 1);

        // One-cycle glitch passes the minimum-filter build only.
        hold(1'b1, 10);
        D = 1'b0;
        tick();
        D = 1'b1;
        fe = 0;
        re = 0;
        for (int e = 2; e <= 8; e++) begin
            tick();
            if (f1 && fe == 0) fe = e;
            if (r1 && re == 0) re = e;
        end
        chk("dut6 glitch fall edge", fe, 4);
        chk("dut6 glitch rise edge", re, 5);
        chk("dut glitch q held", q0, 1);

        // Randomized traffic with occasional enable gaps and resets.
        for (int n = 0; n < 300; n++) begin
            v   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 24));
            EN  = ($urandom_range(0, 9) != 0);
            if (n % 50 == 49) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
            end
            hold(v[0], len);
        end
        EN = 1'b1;
        hold(1'b0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
